// File: rtl/alphamission_snd_pkg.sv
// Shared types and default constants for the Alpha Mission sound-command scheduler.
package alphamission_snd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        ACK    = 3'd3,
        DRAIN  = 3'd4
    } snd_sched_state_t;

    typedef logic [7:0] snd_cmd_t;

    localparam int DEF_DEPTH       = 8;
    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, count is one bit wider.
module snd_cmd_fifo
    import alphamission_snd_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     RESETn,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  snd_cmd_t                 i_din,
    output snd_cmd_t                 o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    snd_cmd_t         r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic             w_wr;
    logic             w_rd;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign w_wr    = i_push && (!o_full || i_pop);
    assign w_rd    = i_pop && !o_empty;
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == {CNT_W{1'b0}});
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_wp  <= {AW{1'b0}};
            r_rp  <= {AW{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_rd) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/alphamission_snd_cmd_sched.sv
// Sound-command scheduler: two CPU skids, round-robin into a FIFO, MCODE/BUSY replay FSM.
// Optional BUSY watchdog enabled by defining SND_CMD_BUSY_WATCHDOG_EN.
module alphamission_snd_cmd_sched
    import alphamission_snd_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC
`ifdef SND_CMD_BUSY_WATCHDOG_EN
    , parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
    input  logic       clk,
    input  logic       RESETn,
    input  logic       pause_cpu,
    input  logic       wr_a,
    input  logic [7:0] din_a,
    input  logic       wr_b,
    input  logic [7:0] din_b,
    input  logic       SND_BUSY,
    output logic [7:0] snd_data,
    output logic       MCODE,
    output logic       fifo_full,
    output logic       ovf,
    output logic       timeout
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PH_MAX = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    logic             r_skid_v_a, r_skid_v_b, r_rr_b, r_ovf, r_mcode;
    snd_cmd_t         r_skid_d_a, r_skid_d_b, r_snd_data;
    snd_sched_state_t r_state;
    logic [PH_W-1:0]  r_ph_cnt;
    logic             w_take_a, w_take_b, w_push, w_pop, w_full, w_empty;
    snd_cmd_t         w_push_d, w_dout;
    logic [CNT_W-1:0] w_count;

    // Round-robin pick between the two skids; r_rr_b set means port B is favoured.
    always_comb begin
        w_take_a = 1'b0;
        w_take_b = 1'b0;
        if (w_full) begin
            w_take_a = 1'b0;
            w_take_b = 1'b0;
        end else if (r_skid_v_a && r_skid_v_b) begin
            w_take_a = !r_rr_b;
            w_take_b = r_rr_b;
        end else begin
            w_take_a = r_skid_v_a;
            w_take_b = r_skid_v_b;
        end
        w_push   = w_take_a || w_take_b;
        w_push_d = w_take_b ? r_skid_d_b : r_skid_d_a;
    end

    // Skid registers, overflow flag and arbitration pointer.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_skid_v_a <= 1'b0;
            r_skid_v_b <= 1'b0;
            r_skid_d_a <= 8'h00;
            r_skid_d_b <= 8'h00;
            r_rr_b     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (wr_a) begin
                if (r_skid_v_a && !w_take_a) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_skid_v_a <= 1'b1;
                    r_skid_d_a <= din_a;
                end
            end else if (w_take_a) begin
                r_skid_v_a <= 1'b0;
            end
            if (wr_b) begin
                if (r_skid_v_b && !w_take_b) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_skid_v_b <= 1'b1;
                    r_skid_d_b <= din_b;
                end
            end else if (w_take_b) begin
                r_skid_v_b <= 1'b0;
            end
            if (r_skid_v_a && r_skid_v_b && w_push) begin
                r_rr_b <= w_take_a;
            end
        end
    end

    snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .RESETn  (RESETn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_push_d),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_pop = (r_state == IDLE) && !pause_cpu && !w_empty && !SND_BUSY;

`ifdef SND_CMD_BUSY_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
`endif

    // Replay FSM; pause_cpu freezes state, phase counter, watchdog and MCODE level.
    always_ff @(posedge clk) begin
        if (!RESETn) begin
            r_state    <= IDLE;
            r_ph_cnt   <= {PH_W{1'b0}};
            r_snd_data <= 8'h00;
            r_mcode    <= 1'b0;
`ifdef SND_CMD_BUSY_WATCHDOG_EN
            r_wd_cnt   <= {WD_W{1'b0}};
            r_timeout  <= 1'b0;
`endif
        end else if (!pause_cpu) begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_snd_data <= w_dout;
                        r_ph_cnt   <= {PH_W{1'b0}};
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_ph_cnt == PH_W'(SETUP_CYC - 1)) begin
                        r_ph_cnt <= {PH_W{1'b0}};
                        r_mcode  <= 1'b1;
                        r_state  <= STROBE;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                STROBE: begin
                    if (r_ph_cnt == PH_W'(STROBE_CYC - 1)) begin
                        r_ph_cnt <= {PH_W{1'b0}};
                        r_mcode  <= 1'b0;
                        r_state  <= ACK;
`ifdef SND_CMD_BUSY_WATCHDOG_EN
                        r_wd_cnt <= {WD_W{1'b0}};
`endif
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                ACK: begin
`ifdef SND_CMD_BUSY_WATCHDOG_EN
                    if (SND_BUSY) begin
                        r_state  <= DRAIN;
                        r_wd_cnt <= {WD_W{1'b0}};
                    end else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
`else
                    if (SND_BUSY) begin
                        r_state <= DRAIN;
                    end
`endif
                end
                DRAIN: begin
`ifdef SND_CMD_BUSY_WATCHDOG_EN
                    if (!SND_BUSY) begin
                        r_state <= IDLE;
                    end else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
`else
                    if (!SND_BUSY) begin
                        r_state <= IDLE;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_mcode <= 1'b0;
                end
            endcase
        end
    end

    assign snd_data  = r_snd_data;
    assign MCODE     = r_mcode;
    assign ovf       = r_ovf;
    assign fifo_full = (w_count == CNT_W'(DEPTH));
`ifdef SND_CMD_BUSY_WATCHDOG_EN
    assign timeout   = r_timeout;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_alphamission_snd_cmd_sched.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_alphamission_snd_cmd_sched;

    localparam int DEPTH = 8;
    localparam int SC    = 2;
    localparam int TC    = 4;

    logic       clk = 1'b0;
    logic       RESETn = 1'b0;
    logic       pause_cpu = 1'b0;
    logic       wr_a = 1'b0, wr_b = 1'b0;
    logic [7:0] din_a = 8'h00, din_b = 8'h00;
    logic       SND_BUSY = 1'b0;
    logic [7:0] snd_data;
    logic       MCODE, fifo_full, ovf, timeout;

    alphamission_snd_cmd_sched #(.DEPTH(DEPTH), .SETUP_CYC(SC), .STROBE_CYC(TC)) dut (
        .clk(clk), .RESETn(RESETn), .pause_cpu(pause_cpu),
        .wr_a(wr_a), .din_a(din_a), .wr_b(wr_b), .din_b(din_b),
        .SND_BUSY(SND_BUSY), .snd_data(snd_data), .MCODE(MCODE),
        .fifo_full(fifo_full), .ovf(ovf), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: command queue plus "age" of the command being replayed.
    bit         m_va, m_vb, m_rrb, m_ovf, m_act, m_seen;
    logic [7:0] m_da, m_db, m_data;
    int         m_age;
    logic [7:0] m_q[$];

    // Sound-CPU model and capture of what the DUT emitted.
    int  bcnt = -1, bclr = 22, lowcnt = 0;
    bit  rand_busy = 1'b0, hold_busy = 1'b0, m_prev = 1'b0, d_prev = 1'b0;
    bq_t emit;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_mcode();
        return m_act && (m_age >= SC) && (m_age < SC + TC);
    endfunction

    function automatic bit m_in_ack();
        return m_act && (m_age >= SC + TC) && !m_seen;
    endfunction

    task automatic model_step();
        int osz;
        bit ta, tb;
        if (!RESETn) begin
            m_va = 0; m_vb = 0; m_rrb = 0; m_ovf = 0; m_act = 0; m_seen = 0;
            m_da = 8'h00; m_db = 8'h00; m_data = 8'h00; m_age = 0;
            m_q.delete();
            return;
        end
        osz = m_q.size();
        if (!pause_cpu) begin
            if (!m_act) begin
                if (osz > 0 && !SND_BUSY) begin
                    m_data = m_q.pop_front();
                    m_act = 1; m_age = 0; m_seen = 0;
                end
            end else if (m_age < SC + TC) begin
                m_age++;
            end else if (!m_seen) begin
                if (SND_BUSY) m_seen = 1;
            end else if (!SND_BUSY) begin
                m_act = 0;
            end
        end
        ta = 0; tb = 0;
        if (osz < DEPTH) begin
            if (m_va && m_vb) begin
                if (m_rrb) tb = 1; else ta = 1;
                m_rrb = ta;
            end else begin
                ta = m_va; tb = m_vb;
            end
        end
        if (ta) m_q.push_back(m_da);
        if (tb) m_q.push_back(m_db);
        if (wr_a) begin
            if (m_va && !ta) m_ovf = 1; else begin m_va = 1; m_da = din_a; end
        end else if (ta) m_va = 0;
        if (wr_b) begin
            if (m_vb && !tb) m_ovf = 1; else begin m_vb = 1; m_db = din_b; end
        end else if (tb) m_vb = 0;
    endtask

    task automatic tick();
        bit em;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (MCODE === 1'b1 && !d_prev) emit.push_back(snd_data);
        d_prev = (MCODE === 1'b1);
        em = exp_mcode();
        if (em && !m_prev) begin
            bcnt = 0;
            bclr = rand_busy ? int'($urandom_range(3, 25)) : 22;
        end else if (bcnt >= 0) bcnt++;
        if (em) lowcnt = 0; else if (lowcnt < 1000) lowcnt++;
        if (bcnt >= bclr && lowcnt >= 3 && !m_in_ack()) bcnt = -1;
        m_prev = em;
        SND_BUSY = hold_busy || (bcnt >= 2);
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("snd_data", snd_data, m_data);
            chk("MCODE", MCODE, exp_mcode());
            chk("fifo_full", fifo_full, (m_q.size() == DEPTH));
            chk("ovf", ovf, m_ovf);
            chk("timeout", timeout, 1'b0);
        end
    end

    task automatic do_reset();
        RESETn = 0; wr_a = 0; wr_b = 0; pause_cpu = 0; hold_busy = 0;
        bcnt = -1; SND_BUSY = 0;
        tick(); tick();
        RESETn = 1;
    endtask

    task automatic wait_idle(input int maxc);
        bit done = 0;
        for (int i = 0; i < maxc && !done; i++) begin
            tick();
            done = !m_act && m_q.size() == 0 && !m_va && !m_vb && !SND_BUSY;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_idle: got busy after %0d cycles, required idle", maxc);
        end
    endtask

    task automatic cmp_order(input string nm, input bq_t exp);
        chk({nm, "_len"}, emit.size(), exp.size());
        for (int i = 0; i < exp.size() && i < emit.size(); i++)
            chk(nm, emit[i], exp[i]);
    endtask

    task automatic wr_port_a(input logic [7:0] d);
        wr_a = 1; din_a = d; tick(); wr_a = 0;
    endtask

    initial begin
        int  hc, first_hi;
        bq_t exp;

        tick();
        chk_en = 1;
        do_reset();
        chk("rst_snd_data", snd_data, 8'h00);
        chk("rst_mcode", MCODE, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_timeout", timeout, 1'b0);

        // Single command: data after k+2, MCODE high for 4 cycles from k+4.
        wr_port_a(8'h3C);
        tick(); tick();
        chk("single_data", snd_data, 8'h3C);
        hc = 0; first_hi = -1;
        for (int i = 3; i < 40; i++) begin
            tick();
            if (MCODE === 1'b1) begin
                hc++;
                if (first_hi < 0) first_hi = i;
            end
        end
        chk("single_rise_edge", first_hi, 4);
        chk("single_hi_len", hc, 4);
        wait_idle(100);

        // Simultaneous pairs: round-robin yields 11,22,44,33.
        do_reset();
        emit.delete();
        wr_a = 1; din_a = 8'h11; wr_b = 1; din_b = 8'h22; tick();
        wr_a = 0; wr_b = 0; tick(); tick();
        wr_a = 1; din_a = 8'h33; wr_b = 1; din_b = 8'h44; tick();
        wr_a = 0; wr_b = 0;
        wait_idle(400);
        exp = '{8'h11, 8'h22, 8'h44, 8'h33};
        cmp_order("rr_order", exp);

        // FIFO full under held BUSY; ninth waits in skid, tenth overflows.
        do_reset();
        hold_busy = 1; SND_BUSY = 1;
        emit.delete();
        for (int i = 0; i < 10; i++) begin
            if (i == 9) chk("ovf_before", ovf, 1'b0);
            wr_port_a(8'hA0 + 8'(i));
            if (i == 7) chk("full_at_7", fifo_full, 1'b0);
            if (i == 9) chk("ovf_after", ovf, 1'b1);
            tick();
            if (i == 7) chk("full_after_8", fifo_full, 1'b1);
        end
        hold_busy = 0;
        wait_idle(1000);
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
        cmp_order("full_order", exp);

        // Pause for 50 cycles inside STROBE stretches MCODE to 54 cycles.
        wr_port_a(8'h5A);
        hc = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (MCODE === 1'b1) hc++;
            if (hc == 2 && pause_cpu == 1'b0 && i < 10) begin
                pause_cpu = 1;
                for (int j = 0; j < 50; j++) begin
                    tick();
                    if (MCODE === 1'b1) hc++;
                    chk("pause_hold", MCODE, 1'b1);
                end
                pause_cpu = 0;
            end
        end
        chk("pause_hi_len", hc, 54);
        wait_idle(200);

        // Reset during STROBE discards queued commands and clears ovf.
        chk("ovf_sticky", ovf, 1'b1);
        wr_port_a(8'h77);
        wr_b = 1; din_b = 8'h78; tick(); wr_b = 0;
        wr_port_a(8'h79);
        for (int i = 0; i < 30 && !exp_mcode(); i++) tick();
        chk("in_strobe", MCODE, 1'b1);
        RESETn = 0; tick(); RESETn = 1;
        chk("rmid_mcode", MCODE, 1'b0);
        chk("rmid_data", snd_data, 8'h00);
        chk("rmid_full", fifo_full, 1'b0);
        chk("rmid_ovf", ovf, 1'b0);
        emit.delete();
        for (int i = 0; i < 60; i++) tick();
        chk("rmid_no_issue", emit.size(), 0);

        // Random traffic, pauses and BUSY timing against the model.
        rand_busy = 1;
        for (int i = 0; i < 4000; i++) begin
            wr_a = ($urandom_range(0, 7) == 0);
            din_a = 8'($urandom);
            wr_b = ($urandom_range(0, 7) == 0);
            din_b = 8'($urandom);
            pause_cpu = ($urandom_range(0, 15) == 0);
            tick();
        end
        wr_a = 0; wr_b = 0; pause_cpu = 0;
        wait_idle(2000);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
